// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM state type and address-field width helpers for wt_cache_ctrl
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    REFILL = 2'd2,
    WRITE  = 2'd3
  } cacheState_t;

  function automatic int byteOffW(input int dataW);
    return (dataW / 8 > 1) ? $clog2(dataW / 8) : 0;
  endfunction

  function automatic int wordOffW(input int wordsPerLine);
    return (wordsPerLine > 1) ? $clog2(wordsPerLine) : 0;
  endfunction

  function automatic int indexW(input int numLines);
    return (numLines > 1) ? $clog2(numLines) : 0;
  endfunction

  function automatic int tagW(input int addrW, input int dataW, input int numLines,
                              input int wordsPerLine);
    return addrW - byteOffW(dataW) - wordOffW(wordsPerLine) - indexW(numLines);
  endfunction

  // Zero-width fields still need a 1-bit carrier signal.
  function automatic int atLeastOne(input int w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wt_write_buffer.sv
// rtl/wt_write_buffer.sv - store FIFO (address + data) drained behind the CPU; used under CACHE_WBUF_EN
module wt_write_buffer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              push,
  input  logic [ADDR_W-1:0] pushAddr,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pop,
  output logic [ADDR_W-1:0] headAddr,
  output logic [DATA_W-1:0] headData,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);

  logic [ADDR_W-1:0] addrMem [WBUF_DEPTH];
  logic [DATA_W-1:0] dataMem [WBUF_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W:0]    count;
  logic              pushOk;
  logic              popOk;

  assign full     = (count == (PTR_W + 1)'(WBUF_DEPTH));
  assign empty    = (count == '0);
  // A full FIFO still takes a push when the head retires in the same cycle.
  assign pushOk   = push && (!full || pop);
  assign popOk    = pop && !empty;
  assign headAddr = addrMem[rdPtr];
  assign headData = dataMem[rdPtr];

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popOk)  rdPtr <= rdPtr + 1'b1;
      if (pushOk && !popOk) begin
        count <= count + 1'b1;
      end else if (!pushOk && popOk) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) begin
      addrMem[wrPtr] <= pushAddr;
      dataMem[wrPtr] <= pushData;
    end
  end

endmodule

// File: rtl/wt_cache_ctrl.sv
// rtl/wt_cache_ctrl.sv - direct-mapped write-through no-allocate cache; CACHE_WBUF_EN adds a store buffer
module wt_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int WBUF_DEPTH     = 4
) (
  input  logic              clk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int BO_W   = byteOffW(DATA_W);
  localparam int WO_W   = wordOffW(WORDS_PER_LINE);
  localparam int IX_W   = indexW(NUM_LINES);
  localparam int TG_W   = tagW(ADDR_W, DATA_W, NUM_LINES, WORDS_PER_LINE);
  localparam int WORD_W = atLeastOne(WO_W);
  localparam int IDX_W  = atLeastOne(IX_W);

  localparam logic [ADDR_W-1:0] WORD_MASK  = ADDR_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK  = ADDR_W'(NUM_LINES - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DATA_W / 8 - 1);
  localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(WORDS_PER_LINE - 1);

  if (WBUF_DEPTH < 2 || (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : gBadDepth
    $error("WBUF_DEPTH must be a power of two >= 2");
  end

  cacheState_t state;
  cacheState_t stateNxt;

  logic [NUM_LINES-1:0] validArr;
  logic [TG_W-1:0]      tagArr  [NUM_LINES];
  logic [DATA_W-1:0]    dataArr [NUM_LINES][WORDS_PER_LINE];

  logic [WORD_W-1:0] curWord;
  logic [IDX_W-1:0]  curIdx;
  logic [TG_W-1:0]   curTag;
  logic [IDX_W-1:0]  missIdx;
  logic [TG_W-1:0]   missTag;
  logic [WORD_W-1:0] refillCnt;
  logic [ADDR_W-1:0] refillAddr;
  logic [ADDR_W-1:0] storeAddr;
  logic              isStore;
  logic              isLoad;
  logic              hit;
  logic              refillBeat;
  logic              refillLast;
  logic              storeAccept;
  logic              writesPending;
  logic              stallInt;
  logic              memWeInt;
  logic [ADDR_W-1:0] wrPortAddr;
  logic [DATA_W-1:0] wrPortData;

  assign curWord   = WORD_W'((cpu_addr >> BO_W) & WORD_MASK);
  assign curIdx    = IDX_W'((cpu_addr >> (BO_W + WO_W)) & LINE_MASK);
  assign curTag    = TG_W'(cpu_addr >> (BO_W + WO_W + IX_W));
  assign storeAddr = cpu_addr & ALIGN_MASK;

  // A simultaneous store and load request is serviced as the store alone.
  assign isStore = cpu_we;
  assign isLoad  = cpu_re && !cpu_we;
  assign hit     = validArr[curIdx] && (tagArr[curIdx] == curTag);

  assign refillAddr = (ADDR_W'(missTag) << (BO_W + WO_W + IX_W))
                    | (ADDR_W'(missIdx) << (BO_W + WO_W))
                    | (ADDR_W'(refillCnt) << BO_W);
  assign refillBeat = (state == REFILL) && mem_ready;
  assign refillLast = (refillCnt == LAST_WORD);

`ifdef CACHE_WBUF_EN
  logic wbPush;
  logic wbPop;
  logic wbFull;
  logic wbEmpty;

  // Stores drain whenever no refill owns the memory port.
  assign memWeInt      = !wbEmpty && ((state == IDLE) || (state == DRAIN));
  assign wbPop         = memWeInt && mem_ready;
  assign wbPush        = (state == IDLE) && isStore && (!wbFull || wbPop);
  assign storeAccept   = wbPush;
  assign writesPending = !wbEmpty;

  wt_write_buffer #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .WBUF_DEPTH (WBUF_DEPTH)
  ) uWriteBuffer (
    .clk      (clk),
    .areset   (areset),
    .push     (wbPush),
    .pushAddr (storeAddr),
    .pushData (cpu_wdata),
    .pop      (wbPop),
    .headAddr (wrPortAddr),
    .headData (wrPortData),
    .full     (wbFull),
    .empty    (wbEmpty)
  );
`else
  assign memWeInt      = (state == WRITE);
  assign storeAccept   = (state == IDLE) && isStore;
  assign writesPending = 1'b0;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wrPortAddr <= '0;
      wrPortData <= '0;
    end else if (storeAccept) begin
      wrPortAddr <= storeAddr;
      wrPortData <= cpu_wdata;
    end
  end
`endif

  always_comb begin
    stateNxt = state;
    stallInt = 1'b0;
    case (state)
      IDLE: begin
        if (isStore) begin
`ifdef CACHE_WBUF_EN
          stallInt = !wbPush;
`else
          stallInt = 1'b1;
          stateNxt = WRITE;
`endif
        end else if (isLoad && !hit) begin
          stallInt = 1'b1;
          stateNxt = writesPending ? DRAIN : REFILL;
        end
      end
      DRAIN: begin
        stallInt = 1'b1;
        if (!writesPending) stateNxt = REFILL;
      end
      REFILL: begin
        stallInt = 1'b1;
        if (mem_ready && refillLast) stateNxt = IDLE;
      end
      WRITE: begin
        // The held store retires in the cycle its handshake completes.
        stallInt = !mem_ready;
        if (mem_ready) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state     <= IDLE;
      validArr  <= '0;
      refillCnt <= '0;
      missIdx   <= '0;
      missTag   <= '0;
    end else begin
      state <= stateNxt;
      if ((state == IDLE) && isLoad && !hit) begin
        missIdx <= curIdx;
        missTag <= curTag;
      end
      if (refillBeat) begin
        refillCnt <= refillLast ? '0 : refillCnt + 1'b1;
        if (refillLast) validArr[missIdx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (refillBeat) dataArr[missIdx][refillCnt] <= mem_rdata;
    if (refillBeat && refillLast) tagArr[missIdx] <= missTag;
    if (storeAccept && hit) dataArr[curIdx][curWord] <= cpu_wdata;
  end

  assign stall     = areset && stallInt;
  assign cpu_rdata = (areset && (state == IDLE) && isLoad && hit) ? dataArr[curIdx][curWord] : '0;
  assign mem_re    = (state == REFILL);
  assign mem_we    = memWeInt;
  assign mem_addr  = (state == REFILL) ? refillAddr : wrPortAddr;
  assign mem_wdata = wrPortData;

endmodule

// File: tb/tb_wt_cache_ctrl.sv
// tb/tb_wt_cache_ctrl.sv - scoreboard bench for wt_cache_ctrl against a line-level cache/memory model
module tb_wt_cache_ctrl;

  logic        clk = 1'b0;
  logic        areset = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  wt_cache_ctrl #(
    .ADDR_W(32), .DATA_W(32), .NUM_LINES(64), .WORDS_PER_LINE(4), .WBUF_DEPTH(4)
  ) dut (
    .clk(clk), .areset(areset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } memOp_t;

  int          nCompared = 0;
  int          nMismatched = 0;
  memOp_t      expMem[$];
  logic [31:0] expLoad[$];
  logic [31:0] memData [logic [31:0]];
  logic [31:0] refMem [logic [31:0]];
  logic [31:0] cachedLine [int];
  int          readyMode = 1;
  bit          quiet = 1'b0;

  function automatic logic [31:0] defaultWord(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : defaultWord(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    nCompared++;
    nMismatched++;
    $display("FAIL %s: actual=0x%0h required=nothing", name, act);
  endtask

  // Memory responder: ready per mode, read data from the memory image.
  always @(negedge clk) begin
    #1;
    case (readyMode)
      0:       mem_ready = 1'b0;
      1:       mem_ready = 1'b1;
      default: mem_ready = ($urandom_range(0, 2) != 0);
    endcase
    mem_rdata = memData.exists(mem_addr) ? memData[mem_addr] : defaultWord(mem_addr);
  end

  // Monitor: every completed memory handshake and accepted load is checked in order.
  always @(negedge clk) begin
    memOp_t e;
    logic [31:0] eLoad;
    #2;
    if (areset && !quiet) begin
      if (mem_re && mem_we) begin
        check("mem_re_we_exclusive", 32'(mem_re & mem_we), 32'h0);
      end else if ((mem_re || mem_we) && mem_ready) begin
        if (expMem.size() == 0) begin
          unexpected("mem_unexpected_handshake", mem_addr);
        end else begin
          e = expMem.pop_front();
          check("mem_direction_we", 32'(mem_we), 32'(e.we));
          check("mem_addr", mem_addr, e.addr);
          if (e.we) check("mem_wdata", mem_wdata, e.data);
        end
        if (mem_we) memData[mem_addr] = mem_wdata;
      end
      if (cpu_re && !cpu_we && !stall) begin
        if (expLoad.size() == 0) begin
          unexpected("load_unexpected", cpu_rdata);
        end else begin
          eLoad = expLoad.pop_front();
          check("load_rdata", cpu_rdata, eLoad);
        end
      end
    end
  end

  // Issue one CPU op at a negedge, push its expected effects, wait until accepted.
  task automatic doOp(input bit we, input bit re, input logic [31:0] addr,
                      input logic [31:0] wdata, output int stallCycles);
    logic [31:0] wa;
    logic [31:0] lb;
    int          idx;
    wa  = addr & ~32'h3;
    lb  = addr & ~32'hF;
    idx = int'((addr >> 4) & 32'h3F);
    if (we) begin
      expMem.push_back('{1'b1, wa, wdata});
      refMem[wa] = wdata;
    end else if (re) begin
      if (!(cachedLine.exists(idx) && cachedLine[idx] == lb)) begin
        for (int k = 0; k < 4; k++) expMem.push_back('{1'b0, lb + 32'(4 * k), 32'h0});
        cachedLine[idx] = lb;
      end
      expLoad.push_back(refRead(wa));
    end
    cpu_we = we;
    cpu_re = re;
    cpu_addr = addr;
    cpu_wdata = wdata;
    stallCycles = 0;
    #3;
    while (stall && stallCycles < 300) begin
      stallCycles++;
      @(negedge clk);
      #3;
    end
    if (stall) unexpected("op_timeout", addr);
    @(negedge clk);
    cpu_we = 1'b0;
    cpu_re = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          sc;
    bit          found;
    int          kind;
    logic [31:0] addr;

    repeat (3) @(negedge clk);
    cpu_re = 1'b1;
    cpu_addr = 32'h100;
    #3;
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_mem_re", 32'(mem_re), 32'h0);
    check("reset_mem_we", 32'(mem_we), 32'h0);
    check("reset_cpu_rdata", cpu_rdata, 32'h0);
    @(negedge clk);
    cpu_re = 1'b0;
    areset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      memData[32'h100 + 32'(4 * k)] = 32'hA0 + 32'(k);
      refMem[32'h100 + 32'(4 * k)]  = 32'hA0 + 32'(k);
    end
    readyMode = 1;
    doOp(1'b0, 1'b1, 32'h100, 32'h0, sc);
    check("load100_stall_cycles", 32'(sc), 32'd5);

    doOp(1'b1, 1'b0, 32'h104, 32'hDEADBEEF, sc);
    doOp(1'b0, 1'b1, 32'h104, 32'h0, sc);
    check("load104_hit_no_stall", 32'(sc), 32'd0);

    doOp(1'b1, 1'b0, 32'h2000, 32'h12345678, sc);
    doOp(1'b0, 1'b1, 32'h2000, 32'h0, sc);
    check("load2000_misses_and_refills", 32'(sc >= 5), 32'h1);

    // Reset in the middle of a refill.
    repeat (10) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    areset = 1'b1;
    cachedLine.delete();
    @(negedge clk);
    quiet = 1'b1;
    cpu_re = 1'b1;
    cpu_addr = 32'h100;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #2;
      if (mem_re && mem_addr == 32'h104) found = 1'b1;
    end
    check("reset_test_reached_word1", 32'(found), 32'h1);
    areset = 1'b0;
    #1;
    check("midrefill_reset_mem_re", 32'(mem_re), 32'h0);
    check("midrefill_reset_mem_we", 32'(mem_we), 32'h0);
    check("midrefill_reset_stall", 32'(stall), 32'h0);
    check("midrefill_reset_rdata", cpu_rdata, 32'h0);
    @(negedge clk);
    areset = 1'b1;
    cpu_re = 1'b0;
    quiet = 1'b0;
    doOp(1'b0, 1'b1, 32'h100, 32'h0, sc);
    check("reload100_misses_again", 32'(sc), 32'd5);

    readyMode = 2;
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      addr = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4)
           | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if (kind < 4)      doOp(1'b0, 1'b1, addr, 32'h0, sc);
      else if (kind < 7) doOp(1'b1, 1'b0, addr, $urandom, sc);
      else if (kind < 8) doOp(1'b1, 1'b1, addr, $urandom, sc);
      else               doOp(1'b0, 1'b0, addr, 32'h0, sc);
    end

`ifdef CACHE_WBUF_EN
    readyMode = 1;
    repeat (10) @(negedge clk);
    readyMode = 0;
    for (int i = 0; i < 4; i++) begin
      doOp(1'b1, 1'b0, 32'h3000 + 32'(4 * i), $urandom, sc);
      check("wbuf_store_no_stall", 32'(sc), 32'd0);
    end
    expMem.push_back('{1'b1, 32'h3010, 32'h55AA55AA});
    refMem[32'h3010] = 32'h55AA55AA;
    cpu_we = 1'b1;
    cpu_addr = 32'h3010;
    cpu_wdata = 32'h55AA55AA;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("wbuf_full_store_stalls", 32'(stall), 32'h1);
      @(negedge clk);
    end
    readyMode = 1;
    sc = 0;
    #3;
    while (stall && sc < 10) begin
      sc++;
      @(negedge clk);
      #3;
    end
    check("wbuf_release_on_first_ready", 32'(!stall && mem_ready), 32'h1);
    @(negedge clk);
    cpu_we = 1'b0;

    repeat (10) @(negedge clk);
    readyMode = 0;
    doOp(1'b1, 1'b0, 32'h4000, 32'hCAFE0001, sc);
    check("wbuf_pending_store0_no_stall", 32'(sc), 32'd0);
    doOp(1'b1, 1'b0, 32'h4004, 32'hCAFE0002, sc);
    check("wbuf_pending_store1_no_stall", 32'(sc), 32'd0);
    readyMode = 1;
    doOp(1'b0, 1'b1, 32'h4000, 32'h0, sc);
    check("drain_then_refill_stalls", 32'(sc >= 6), 32'h1);
`endif

    readyMode = 1;
    repeat (20) @(negedge clk);
    check("exp_mem_queue_empty", 32'(expMem.size()), 32'h0);
    check("exp_load_queue_empty", 32'(expLoad.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/wt_cache_ctrl.md
WT_CACHE_CTRL -- requirements
Module: wt_cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width; byte offset bits = log2(DATA_W/8).
REQ-003 SHALL have parameter NUM_LINES, default 64, direct-mapped lines, power of two.
REQ-004 SHALL have parameter WORDS_PER_LINE, default 4, power of two >= 1.
REQ-005 SHALL have parameter WBUF_DEPTH, default 4, write-buffer entries, power of two >= 2.
REQ-006 SHALL have ports: clk in 1, clock; areset in 1, reset, asynchronous and active-low.
REQ-007 SHALL have ports: cpu_addr in ADDR_W, cpu address; cpu_wdata in DATA_W, store data; cpu_we in 1, store; cpu_re in 1, load.
REQ-008 SHALL have ports: cpu_rdata out DATA_W, load data; stall out 1, freeze CPU.
REQ-009 SHALL have ports: mem_addr out ADDR_W, word-aligned; mem_wdata out DATA_W; mem_we out 1; mem_re out 1; mem_rdata in DATA_W; mem_ready in 1, handshake completes.

Function
REQ-010 SHALL use line layout {tag, index, word offset, byte offset} derived from the parameters; per line: valid bit, tag, WORDS_PER_LINE data words.
REQ-011 SHALL use FSM states IDLE, DRAIN, REFILL, WRITE; reset state IDLE.
REQ-012 SHALL return a read hit combinationally in IDLE: stall=0, cpu_rdata=line word in the same cycle.
REQ-013 SHALL, on a read miss in IDLE, raise stall combinationally that cycle; next state DRAIN if any write is pending, else REFILL.
REQ-014 SHALL, in REFILL, fetch words 0..WORDS_PER_LINE-1 of the line, one mem_re handshake each; on the last mem_ready set valid, write tag, return IDLE; the retried load then hits with stall=0.
REQ-015 SHALL hold mem_addr/mem_wdata/mem_re/mem_we stable until mem_ready is sampled high; mem_re and mem_we never high together.
REQ-016 SHALL, on a write hit, update the cached word the same edge; on a write miss, not allocate (valid/tag unchanged); both write through to memory.
REQ-017 SHALL treat cpu_we=1 with cpu_re=1 as a write only.
REQ-018 SHALL ignore mem_ready while mem_re=mem_we=0.
REQ-019 SHALL have a refill latency of WORDS_PER_LINE handshakes plus one IDLE cycle for the hit.

Reset
REQ-020 SHALL, on areset low at any time, including mid-refill or mid-write: clear all valid bits, enter IDLE, empty the write buffer, drive mem_re=mem_we=0, stall=0, cpu_rdata=0; the in-flight memory transaction is abandoned.
REQ-021 SHALL leave data and tag arrays uninitialised by reset.

Configuration
REQ-022 SHALL, with CACHE_WBUF_EN defined: enqueue each store into a WBUF_DEPTH FIFO and drain it in the background; stall=0 for a store unless the FIFO is full; a store arriving with the FIFO full stalls until an entry retires.
REQ-023 SHALL, with CACHE_WBUF_EN defined: in DRAIN, empty the FIFO before REFILL so refills never see stale memory; a push and pop in the same cycle keep the count unchanged.
REQ-024 SHALL, without CACHE_WBUF_EN: send each store through WRITE, stall high from the store cycle until the cycle mem_ready is sampled; DRAIN is never entered; WBUF_DEPTH is unused.

Structure
REQ-025 SHALL place the FSM state enum and the width functions (offset, index, tag widths from the parameters) in shared package cache_pkg.
REQ-026 SHALL implement the FIFO as sub-module wt_write_buffer (parameters DATA_W, ADDR_W, WBUF_DEPTH; push/pop/full/empty), instantiated only under CACHE_WBUF_EN.

Verification
REQ-027 SHALL cover: reset, load 0x100 with mem returning 0xA0..0xA3, ready every cycle -> 4 mem_re handshakes at 0x100..0x10C, stall 5 cycles, then cpu_rdata=0xA0 with stall=0.
REQ-028 SHALL cover: after REQ-027, store 0xDEADBEEF to 0x104, then load 0x104 -> mem write 0xDEADBEEF@0x104, load hits returning 0xDEADBEEF, no mem_re.
REQ-029 SHALL cover: store to uncached 0x2000, then load 0x2000 -> no allocate, the load misses and refills.
REQ-030 SHALL cover: CACHE_WBUF_EN, mem_ready held low, 5 stores with WBUF_DEPTH=4 -> stall=0 for 4 stores, stall=1 on the 5th until the first mem_ready.
REQ-031 SHALL cover: areset pulsed low during the 2nd refill word -> mem_re=0 immediately, stall=0, the reload of 0x100 misses again.
REQ-032 SHALL cover: CACHE_WBUF_EN, 2 stores pending then read miss -> both mem_we handshakes complete before the first mem_re.
